color_correction_matrix: RTL and testbench

- Stage directly downstream of the Bayer demosaic. Consumes its 8-bit R/G/B stream with valid/done strobes.
- Applies a programmable 3x3 signed colour-correction matrix with rounding and clamp.
- Emits corrected 8-bit RGB with the valid/done strobes delayed to match.
- Coefficients are double-buffered. A write made mid-frame takes effect only at a frame boundary.

---
 rtl/color_correction_matrix_if.sv | 31 +++
 rtl/color_correction_matrix.sv | 140 ++++++++++++++
 tb/tb_color_correction_matrix.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/color_correction_matrix_if.sv
// Pixel stream, coefficient-write and status signals for the colour-correction matrix.
// The master drives pixels and coefficients; the slave returns corrected pixels and status.
interface color_correction_matrix_if #(
    parameter int COEF_W = 12
);
    logic [7:0]               iR;
    logic [7:0]               iG;
    logic [7:0]               iB;
    logic                     iValid;
    logic                     iDone;
    logic                     coefWe;
    logic [3:0]               coefAddr;
    logic signed [COEF_W-1:0] coefData;
    logic [7:0]               oR;
    logic [7:0]               oG;
    logic [7:0]               oB;
    logic                     oValid;
    logic                     oDone;
    logic [31:0]              pixelCnt;
    logic                     busy;

    modport master (
        output iR, iG, iB, iValid, iDone, coefWe, coefAddr, coefData,
        input  oR, oG, oB, oValid, oDone, pixelCnt, busy
    );

    modport slave (
        input  iR, iG, iB, iValid, iDone, coefWe, coefAddr, coefData,
        output oR, oG, oB, oValid, oDone, pixelCnt, busy
    );
endinterface

// File: rtl/color_correction_matrix.sv
// 3x3 signed colour-correction matrix over a 3-stage pipeline (products, sums, round/clamp).
// Coefficients are written to a shadow bank and committed to the active bank at frame boundaries.
module color_correction_matrix #(
    parameter int COEF_W    = 12,
    parameter int FRAC_BITS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    color_correction_matrix_if.slave bus
);
    localparam int PROD_W = COEF_W + 9;
    localparam int SUM_W  = PROD_W + 2;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1 << FRAC_BITS);
    localparam logic signed [SUM_W-1:0]  ROUND    = SUM_W'(1 << (FRAC_BITS - 1));

    logic signed [COEF_W-1:0] r_shadow [9];
    logic signed [COEF_W-1:0] r_active [9];
    logic                     r_pending;
    logic [0:0]               r_state;

    logic signed [PROD_W-1:0] r_prod [9];
    logic signed [SUM_W-1:0]  r_sum  [3];
    logic                     r_v1, r_d1, r_v2, r_d2;
    logic [7:0]               r_oR, r_oG, r_oB;
    logic                     r_oValid, r_oDone;
    logic [31:0]              r_pixelCnt;

    logic [7:0]               w_px    [3];
    logic signed [SUM_W-1:0]  w_shift [3];
    logic [7:0]               w_rc    [3];
    logic                     w_coef_wr;
    logic                     w_commit;

    always_comb begin
        w_px[0]   = bus.iR;
        w_px[1]   = bus.iG;
        w_px[2]   = bus.iB;
        w_coef_wr = bus.coefWe && (bus.coefAddr <= 4'd8);
        w_commit  = r_pending && ((r_state == ST_IDLE) || bus.iDone);
    end

    // Commit copies the shadow as it stood before this edge's write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) begin
                r_shadow[i] <= (i == 0 || i == 4 || i == 8) ? COEF_ONE : '0;
                r_active[i] <= (i == 0 || i == 4 || i == 8) ? COEF_ONE : '0;
            end
            r_pending <= 1'b0;
        end else begin
            if (w_commit) begin
                for (int i = 0; i < 9; i++) r_active[i] <= r_shadow[i];
            end
            if (w_coef_wr) begin
                r_shadow[bus.coefAddr] <= bus.coefData;
                r_pending              <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else if (bus.iDone) begin
            r_state <= ST_IDLE;
        end else if (bus.iValid) begin
            r_state <= ST_ACTIVE;
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_shift[r] = (r_sum[r] + ROUND) >>> FRAC_BITS;
            if (w_shift[r][SUM_W-1]) begin
                w_rc[r] = 8'd0;
            end else if (w_shift[r] > SUM_W'(255)) begin
                w_rc[r] = 8'hFF;
            end else begin
                w_rc[r] = w_shift[r][7:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) r_prod[i] <= '0;
            for (int r = 0; r < 3; r++) r_sum[r] <= '0;
            r_v1       <= 1'b0;
            r_d1       <= 1'b0;
            r_v2       <= 1'b0;
            r_d2       <= 1'b0;
            r_oR       <= 8'd0;
            r_oG       <= 8'd0;
            r_oB       <= 8'd0;
            r_oValid   <= 1'b0;
            r_oDone    <= 1'b0;
            r_pixelCnt <= 32'd0;
        end else begin
            // Row-major: coefficient i maps input channel i%3 into output channel i/3.
            for (int i = 0; i < 9; i++) begin
                r_prod[i] <= $signed(PROD_W'(r_active[i])) *
                             $signed(PROD_W'({1'b0, w_px[i % 3]}));
            end
            for (int r = 0; r < 3; r++) begin
                r_sum[r] <= SUM_W'(r_prod[3*r]) + SUM_W'(r_prod[3*r+1]) + SUM_W'(r_prod[3*r+2]);
            end
            r_v1 <= bus.iValid;
            r_d1 <= bus.iDone;
            r_v2 <= r_v1;
            r_d2 <= r_d1;
            if (r_v2) begin
                r_oR <= w_rc[0];
                r_oG <= w_rc[1];
                r_oB <= w_rc[2];
            end
            r_oValid <= r_v2;
            r_oDone  <= r_d2;
            // Count tracks the pixel being presented, so a pixel arriving with the clear counts as 1.
            if (r_oDone) begin
                r_pixelCnt <= {31'd0, r_v2};
            end else if (r_v2) begin
                r_pixelCnt <= r_pixelCnt + 32'd1;
            end
        end
    end

    assign bus.oR       = r_oR;
    assign bus.oG       = r_oG;
    assign bus.oB       = r_oB;
    assign bus.oValid   = r_oValid;
    assign bus.oDone    = r_oDone;
    assign bus.pixelCnt = r_pixelCnt;
    assign bus.busy     = (r_state == ST_ACTIVE);
endmodule

// File: tb/tb_color_correction_matrix.sv
// Bench for color_correction_matrix: directed scenarios plus randomized frames checked
// against an integer-arithmetic matrix model.
`timescale 1ns/1ps
module tb_color_correction_matrix;
    logic clk = 1'b0;
    logic reset;

    color_correction_matrix_if #(.COEF_W(12)) bus ();

    color_correction_matrix #(.COEF_W(12), .FRAC_BITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int m_coef [9];

    function automatic logic [7:0] ref_ch(input int row, input int r, input int g, input int b);
        int v;
        v = m_coef[3*row] * r + m_coef[3*row+1] * g + m_coef[3*row+2] * b;
        v = (v + 128) >>> 8;
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    task automatic set_identity();
        for (int i = 0; i < 9; i++) m_coef[i] = (i == 0 || i == 4 || i == 8) ? 256 : 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.iR = 8'd0; bus.iG = 8'd0; bus.iB = 8'd0;
        bus.iValid = 1'b0; bus.iDone = 1'b0;
        bus.coefWe = 1'b0; bus.coefAddr = 4'd0; bus.coefData = 12'sd0;
    endtask

    task automatic write_coef(input int addr, input int data);
        bus.coefWe = 1'b1; bus.coefAddr = 4'(addr); bus.coefData = 12'(data);
        step();
        bus.coefWe = 1'b0;
    endtask

    task automatic end_frame();
        bus.iValid = 1'b0; bus.iDone = 1'b1;
        step();
        bus.iDone = 1'b0;
        repeat (4) step();
    endtask

    task automatic send_pixel(input int r, input int g, input int b,
                              output logic [7:0] or_, output logic [7:0] og,
                              output logic [7:0] ob, output logic ov);
        bus.iR = 8'(r); bus.iG = 8'(g); bus.iB = 8'(b); bus.iValid = 1'b1;
        step();
        bus.iValid = 1'b0;
        step();
        step();
        or_ = bus.oR; og = bus.oG; ob = bus.oB; ov = bus.oValid;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        set_identity();
        #2;
        n_checks++;
        if (bus.oValid !== 1'b0 || bus.oDone !== 1'b0)
            $display("FAIL reset_strobes: got v=%b d=%b required 0 0", bus.oValid, bus.oDone);
        else n_pass++;
        n_checks++;
        if ({bus.oR, bus.oG, bus.oB} !== 24'd0 || bus.pixelCnt !== 32'd0 || bus.busy !== 1'b0)
            $display("FAIL reset_data: got rgb=%h cnt=%0d busy=%b required 0", {bus.oR, bus.oG, bus.oB},
                     bus.pixelCnt, bus.busy);
        else n_pass++;
        #10;
        reset = 1'b0;
        step();
    endtask

    task automatic test_identity();
        bus.iR = 8'd10; bus.iG = 8'd200; bus.iB = 8'd37; bus.iValid = 1'b1;
        step();
        bus.iValid = 1'b0;
        n_checks++;
        if (bus.oValid !== 1'b0) $display("FAIL ident_early1: got oValid=%b required 0", bus.oValid);
        else n_pass++;
        step();
        n_checks++;
        if (bus.oValid !== 1'b0) $display("FAIL ident_early2: got oValid=%b required 0", bus.oValid);
        else n_pass++;
        step();
        n_checks++;
        if (bus.oValid !== 1'b1 || bus.oR !== 8'd10 || bus.oG !== 8'd200 || bus.oB !== 8'd37)
            $display("FAIL ident_pixel: got v=%b rgb=%0d/%0d/%0d required 1 10/200/37",
                     bus.oValid, bus.oR, bus.oG, bus.oB);
        else n_pass++;
        n_checks++;
        if (bus.pixelCnt !== 32'd1) $display("FAIL ident_cnt: got %0d required 1", bus.pixelCnt);
        else n_pass++;
        end_frame();
    endtask

    task automatic test_rounding();
        logic [7:0] r, g, b;
        logic v;
        write_coef(0, 128);
        step();
        send_pixel(3, 0, 0, r, g, b, v);
        n_checks++;
        if (v !== 1'b1 || r !== 8'd2) $display("FAIL round_3: got v=%b oR=%0d required 1 2", v, r);
        else n_pass++;
        send_pixel(1, 0, 0, r, g, b, v);
        n_checks++;
        if (v !== 1'b1 || r !== 8'd1) $display("FAIL round_1: got v=%b oR=%0d required 1 1", v, r);
        else n_pass++;
        end_frame();
    endtask

    task automatic test_clamp();
        logic [7:0] r, g, b;
        logic v;
        write_coef(0, 512);
        end_frame();
        send_pixel(200, 0, 0, r, g, b, v);
        n_checks++;
        if (r !== 8'd255) $display("FAIL clamp_high: got oR=%0d required 255", r);
        else n_pass++;
        write_coef(0, -256);
        end_frame();
        send_pixel(50, 0, 0, r, g, b, v);
        n_checks++;
        if (r !== 8'd0) $display("FAIL clamp_low: got oR=%0d required 0", r);
        else n_pass++;
        write_coef(0, 256);
        write_coef(3, -128);
        end_frame();
        send_pixel(255, 100, 0, r, g, b, v);
        n_checks++;
        if (g !== 8'd0 || r !== 8'd255)
            $display("FAIL clamp_mix: got oR=%0d oG=%0d required 255 0", r, g);
        else n_pass++;
        write_coef(3, 0);
        end_frame();
        set_identity();
    endtask

    task automatic test_deferred();
        logic [7:0] rs [8];
        logic       vs [8];
        logic       ds [8];
        int         cs [8];
        logic [7:0] r, g, b;
        logic v;
        for (int s = 0; s < 8; s++) begin
            clear_inputs();
            if (s < 4) begin
                bus.iR = 8'd100; bus.iG = 8'd100; bus.iB = 8'd100; bus.iValid = 1'b1;
                bus.iDone = (s == 3);
            end
            if (s == 1) begin
                bus.coefWe = 1'b1; bus.coefAddr = 4'd0; bus.coefData = 12'sd0;
                n_checks++;
                if (bus.busy !== 1'b1) $display("FAIL defer_busy: got %b required 1", bus.busy);
                else n_pass++;
            end
            step();
            rs[s] = bus.oR; vs[s] = bus.oValid; ds[s] = bus.oDone; cs[s] = int'(bus.pixelCnt);
        end
        clear_inputs();
        for (int s = 2; s < 6; s++) begin
            n_checks++;
            if (vs[s] !== 1'b1 || rs[s] !== 8'd100)
                $display("FAIL defer_old_px%0d: got v=%b oR=%0d required 1 100", s - 1, vs[s], rs[s]);
            else n_pass++;
        end
        n_checks++;
        if (ds[5] !== 1'b1 || cs[5] != 4 || cs[6] != 0)
            $display("FAIL defer_done: got done=%b cnt=%0d,%0d required 1 4,0", ds[5], cs[5], cs[6]);
        else n_pass++;
        send_pixel(100, 100, 100, r, g, b, v);
        n_checks++;
        if (r !== 8'd0 || g !== 8'd100)
            $display("FAIL defer_new: got oR=%0d oG=%0d required 0 100", r, g);
        else n_pass++;
        write_coef(0, 256);
        end_frame();
    endtask

    task automatic test_gaps_done();
        logic [7:0] rs [8];
        logic       vs [8];
        logic       ds [8];
        int         cs [8];
        logic [3:0] pat;
        pat = 4'b1101;
        for (int s = 0; s < 8; s++) begin
            clear_inputs();
            if (s < 4) begin
                bus.iValid = pat[s];
                bus.iDone  = (s == 3);
                bus.iR = 8'(20 + 25 * s); bus.iG = 8'(40 + 5 * s); bus.iB = 8'(60 + s);
            end
            step();
            rs[s] = bus.oR; vs[s] = bus.oValid; ds[s] = bus.oDone; cs[s] = int'(bus.pixelCnt);
        end
        clear_inputs();
        n_checks++;
        if ({vs[2], vs[3], vs[4], vs[5]} !== 4'b1011)
            $display("FAIL gap_valid: got %b%b%b%b required 1011", vs[2], vs[3], vs[4], vs[5]);
        else n_pass++;
        n_checks++;
        if (ds[4] !== 1'b0 || ds[5] !== 1'b1 || ds[6] !== 1'b0)
            $display("FAIL gap_done: got %b%b%b required 010", ds[4], ds[5], ds[6]);
        else n_pass++;
        n_checks++;
        if (rs[3] !== 8'd20 || rs[5] !== 8'd95)
            $display("FAIL gap_hold: got oR=%0d,%0d required 20,95", rs[3], rs[5]);
        else n_pass++;
        n_checks++;
        if (cs[5] != 3 || cs[6] != 0)
            $display("FAIL gap_cnt: got %0d,%0d required 3,0", cs[5], cs[6]);
        else n_pass++;
    endtask

    task automatic test_random();
        localparam int N = 16;
        logic [7:0] er [N];
        logic [7:0] eg [N];
        logic [7:0] eb [N];
        logic       ev [N];
        logic       ed [N];
        int         pr [N];
        int         pg [N];
        int         pb [N];
        int         run;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 9; i++) begin
                m_coef[i] = int'($urandom_range(0, 4095)) - 2048;
                write_coef(i, m_coef[i]);
            end
            step();
            for (int k = 0; k < N; k++) begin
                pr[k] = int'($urandom_range(0, 255));
                pg[k] = int'($urandom_range(0, 255));
                pb[k] = int'($urandom_range(0, 255));
                ev[k] = ($urandom_range(0, 3) != 0);
                ed[k] = (k == N - 1);
                er[k] = ref_ch(0, pr[k], pg[k], pb[k]);
                eg[k] = ref_ch(1, pr[k], pg[k], pb[k]);
                eb[k] = ref_ch(2, pr[k], pg[k], pb[k]);
            end
            run = 0;
            for (int s = 0; s < N + 3; s++) begin
                int k;
                clear_inputs();
                if (s < N) begin
                    bus.iR = 8'(pr[s]); bus.iG = 8'(pg[s]); bus.iB = 8'(pb[s]);
                    bus.iValid = ev[s]; bus.iDone = ed[s];
                end
                step();
                k = s - 2;
                if (k >= 0 && k < N) begin
                    n_checks++;
                    if (bus.oValid !== ev[k] || bus.oDone !== ed[k])
                        $display("FAIL rand_strobe f%0d k%0d: got v=%b d=%b required %b %b",
                                 f, k, bus.oValid, bus.oDone, ev[k], ed[k]);
                    else n_pass++;
                    if (ev[k]) begin
                        run++;
                        n_checks++;
                        if (bus.oR !== er[k] || bus.oG !== eg[k] || bus.oB !== eb[k] ||
                            bus.pixelCnt !== 32'(run))
                            $display("FAIL rand_px f%0d k%0d: got %0d/%0d/%0d cnt=%0d required %0d/%0d/%0d cnt=%0d",
                                     f, k, bus.oR, bus.oG, bus.oB, bus.pixelCnt,
                                     er[k], eg[k], eb[k], run);
                        else n_pass++;
                    end
                end else if (k == N) begin
                    n_checks++;
                    if (bus.pixelCnt !== 32'd0)
                        $display("FAIL rand_cnt_clear f%0d: got %0d required 0", f, bus.pixelCnt);
                    else n_pass++;
                end
            end
            clear_inputs();
            step();
        end
        for (int i = 0; i < 9; i++) write_coef(i, (i == 0 || i == 4 || i == 8) ? 256 : 0);
        step();
        set_identity();
    endtask

    task automatic test_async_reset();
        logic [7:0] r, g, b;
        logic v;
        int stale;
        write_coef(0, 0);
        end_frame();
        send_pixel(50, 60, 70, r, g, b, v);
        n_checks++;
        if (r !== 8'd0 || g !== 8'd60) $display("FAIL arst_pre: got oR=%0d oG=%0d required 0 60", r, g);
        else n_pass++;
        write_coef(4, 0);
        bus.iR = 8'd90; bus.iG = 8'd90; bus.iB = 8'd90; bus.iValid = 1'b1;
        step();
        step();
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.oValid !== 1'b0 || {bus.oR, bus.oG, bus.oB} !== 24'd0 ||
            bus.pixelCnt !== 32'd0 || bus.busy !== 1'b0)
            $display("FAIL arst_now: got v=%b rgb=%h cnt=%0d busy=%b required 0",
                     bus.oValid, {bus.oR, bus.oG, bus.oB}, bus.pixelCnt, bus.busy);
        else n_pass++;
        clear_inputs();
        #2;
        reset = 1'b0;
        stale = 0;
        for (int s = 0; s < 5; s++) begin
            step();
            if (bus.oValid !== 1'b0) stale++;
        end
        n_checks++;
        if (stale != 0) $display("FAIL arst_stale: got %0d stale valids required 0", stale);
        else n_pass++;
        send_pixel(10, 200, 37, r, g, b, v);
        n_checks++;
        if (v !== 1'b1 || r !== 8'd10 || g !== 8'd200 || b !== 8'd37)
            $display("FAIL arst_identity: got v=%b %0d/%0d/%0d required 1 10/200/37", v, r, g, b);
        else n_pass++;
        end_frame();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_rounding();
        test_clamp();
        test_deferred();
        test_gaps_done();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
